mdio_receptor: RTL and testbench
================================

// Module: mdio_receptor
// PURPOSE
//  MDIO management target (PHY side), the far end of the team's MDIO frame generator (management controller).
//  Decodes Clause-22 frames sampled on MDC, writes a local register file on WRITE.
//  Serially returns register data on READ by driving MDIO_OUT/MDIO_OE.
//  Sits between the MDIO pins and a 32x16 register bank owned by the PHY model.
// PARAMETERS
//  PHY_ADDR   5'd0   address this target answers to; other addresses are ignored
//  MIN_PRE    32     consecutive '1' bits required before ST (used only with MDIO_PREAMBLE_CHECK_EN)
// PORTS
//  clk        in   1   system clock; MDC is synchronous to clk, min high/low time 1 clk
//  rst        in   1   synchronous, active-high reset
//  MDC        in   1   management clock from controller
//  MDIO_IN    in   1   serial data from controller (valid around MDC rising edge)
//  RD_DATA    in   16  register read data, valid 1 clk after RD_REQ
//  MDIO_OUT   out  1   serial data to controller
//  MDIO_OE    out  1   1 = target drives MDIO line
//  REG_ADDR   out  5   decoded register address, held until next frame decodes one
//  WR_DATA    out  16  write data, valid with WR_STB
//  WR_STB     out  1   1-clk write strobe
//  RD_REQ     out  1   1-clk read request
//  FRAME_ERR  out  1   1-clk pulse on malformed frame
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit counter 0; shift registers 0. rst mid-frame drops MDIO_OE same edge.
//  Edges: mdc_q <= MDC each clk; rise = MDC & ~mdc_q; fall = ~MDC & mdc_q. MDIO_IN sampled only on rise.
//  Frame bit index n (0..31, counted on rise): 0-1 ST=01, 2-3 OP, 4-8 PHYAD MSB first, 9-13 REGAD, 14-15 TA, 16-31 DATA.
//  States: IDLE -> HDR -> {WR_TA, RD_TA, SKIP} -> {WR_DATA, RD_DATA} -> IDLE.
//   IDLE: wait for sampled 0 then 1 (ST); the 1 enters HDR with n=2. A 0 followed by 0 stays IDLE.
//   HDR: shift bits 2..13. At n=13 rise: OP=10 & PHYAD==PHY_ADDR -> RD_TA, REG_ADDR<=REGAD, RD_REQ=1 next clk;
//        OP=01 & match -> WR_TA, REG_ADDR<=REGAD; OP 00/11 -> SKIP, FRAME_ERR pulse; no match -> SKIP, no error.
//   RD_TA: capture RD_DATA the clk after RD_REQ. OE stays 0 through bit 14; on the fall after n=14 rise:
//        MDIO_OE=1, MDIO_OUT=0 (TA second bit). Next state RD_DATA.
//   RD_DATA: on each fall after n=15..30 rise, MDIO_OUT <= data[15..0] MSB first; on fall after n=31 rise:
//        MDIO_OE=0, MDIO_OUT=0, -> IDLE.
//   WR_TA: sample n=14,15; expect 1,0. Mismatch -> SKIP + FRAME_ERR pulse.
//   WR_DATA: shift n=16..31; clk after n=31 rise: WR_DATA valid, WR_STB=1 for 1 clk, -> IDLE.
//   SKIP: never drives, no strobes; count to n=31 then IDLE.
//  Counter: 5-bit, wraps 31->0 only on return to IDLE; never free-runs.
//  MDC stalled: state and outputs hold indefinitely (no timeout).
//  MDC rise and fall cannot coincide; rst has priority over every edge event.
// CONFIGURATION
//  MDIO_PREAMBLE_CHECK_EN defined: IDLE counts consecutive '1' rises (saturating at MIN_PRE); ST accepted only
//   if count >= MIN_PRE, otherwise frame -> SKIP with FRAME_ERR pulse; count clears on any 0 or frame end.
//  Not defined: preamble ignored, ST detected directly from IDLE (preamble suppression per 802.3 22.2.4.5.2).
// STRUCTURE
//  Shared include mdio_defs.vh: ST_CODE=2'b01, OP_WR=2'b01, OP_RD=2'b10, TA_WR=2'b10, bit-index constants
//   (PHY_MSB=4, REG_MSB=9, TA_BIT=14, DATA_MSB=16), state encodings; also consumed by the generator.
//  Sub-module mdc_edge_det (clk, rst, MDC -> rise, fall). Everything else in mdio_receptor.
// TESTING
//  Write: PHY_ADDR=3, frame 01_01_00011_00101_10_A5A5 -> REG_ADDR=5, WR_DATA=16'hA5A5, one WR_STB, OE never 1.
//  Read: frame 01_10_00011_00111_Z0, RD_DATA=16'h1234 -> RD_REQ once, OE=1 bits 15..31, line shows 0 then 1234 MSB first, OE=0 after.
//  Address miss: write to PHYAD=4 with PHY_ADDR=3 -> no WR_STB, no RD_REQ, no FRAME_ERR, OE stays 0, next valid frame accepted.
//  Bad OP 11 or write TA=00 -> one FRAME_ERR pulse, no WR_STB, returns IDLE after bit 31.
//  rst asserted at bit 20 of a read -> same edge OE=0, all outputs 0; following write frame decodes correctly.
//  MDIO_PREAMBLE_CHECK_EN, MIN_PRE=32: 31 ones + write -> FRAME_ERR, no strobe; 32 ones + write -> WR_STB.

Source files
------------

// File: rtl/mdio_receptor_pkg.sv
// -----------------------------------------------------------------------------
// mdio_receptor_pkg
//   Shared Clause-22 MDIO definitions: frame field codes, bit-index landmarks
//   of the 32-bit frame body, the receptor state encoding and the header
//   layout. Consumed by mdio_receptor and by the frame generator side.
// -----------------------------------------------------------------------------
package mdio_receptor_pkg;

    // Field codes
    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    // Bit indices within the frame body (ST is bits 0-1)
    localparam logic [4:0] TA_BIT   = 5'd14;
    localparam logic [4:0] DATA_MSB = 5'd16;
    localparam logic [4:0] HDR_LAST = TA_BIT - 5'd1;
    localparam logic [4:0] LAST_BIT = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR_TA,
        ST_RD_TA,
        ST_SKIP,
        ST_WR_DATA,
        ST_RD_DATA
    } state_e;

    // Header bits 2..13 in arrival order
    typedef struct packed {
        logic [1:0] op;
        logic [4:0] phyad;
        logic [4:0] regad;
    } hdr_t;

endpackage

// File: rtl/mdc_edge_det.sv
// -----------------------------------------------------------------------------
// mdc_edge_det
//   Detects rising and falling edges of MDC in the clk domain. MDC is
//   synchronous to clk, so a single history flop is enough.
// Ports
//   clk   in  system clock
//   rst   in  synchronous, active-high reset
//   MDC   in  management clock from the controller
//   rise  out 1 while MDC is high and was low on the previous clk
//   fall  out 1 while MDC is low and was high on the previous clk
// -----------------------------------------------------------------------------
module mdc_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic MDC,
    output logic rise,
    output logic fall
);

    logic mdc_d;
    logic mdc_q;

    always_comb begin
        mdc_d = MDC;
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc_d;
        end
    end

    assign rise = MDC & ~mdc_q;
    assign fall = ~MDC & mdc_q;

endmodule

// File: rtl/mdio_receptor.sv
// -----------------------------------------------------------------------------
// mdio_receptor
//   Clause-22 MDIO management target (PHY side). Decodes frames sampled on
//   MDC rising edges, issues register writes, and serially returns register
//   data on reads by driving MDIO_OUT/MDIO_OE on MDC falling edges.
// Parameters
//   PHY_ADDR  address this target answers to
//   MIN_PRE   preamble ones required before ST (only with the macro below)
// Configuration
//   MDIO_PREAMBLE_CHECK_EN  when defined, ST is accepted only after MIN_PRE
//                           consecutive '1' bits; otherwise preamble ignored.
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   MDC        management clock          MDIO_IN   serial data in
//   RD_DATA    read data, valid 1 clk after RD_REQ
//   MDIO_OUT   serial data out           MDIO_OE   1 = target drives line
//   REG_ADDR   decoded register address, held until next decode
//   WR_DATA    write data, valid with WR_STB
//   WR_STB     1-clk write strobe        RD_REQ    1-clk read request
//   FRAME_ERR  1-clk pulse on a malformed frame
// -----------------------------------------------------------------------------
module mdio_receptor
    import mdio_receptor_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd0
`ifdef MDIO_PREAMBLE_CHECK_EN
    ,
    parameter int MIN_PRE = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_IN,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [4:0]  REG_ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_REQ,
    output logic        FRAME_ERR
);

    logic rise;
    logic fall;

    mdc_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .MDC  (MDC),
        .rise (rise),
        .fall (fall)
    );

    state_e      state_q,     state_d;
    logic [4:0]  n_q,         n_d;          // index of the next bit to arrive
    logic        zero_seen_q, zero_seen_d;  // last IDLE sample was 0
    logic        tail_q,      tail_d;       // bit 31 of a read has been clocked
    logic [10:0] hdr_sr_q,    hdr_sr_d;
    logic [15:0] data_sr_q,   data_sr_d;
    logic        rd_cap_q,    rd_cap_d;     // RD_DATA is valid this clk
    logic        oe_q,        oe_d;
    logic        out_q,       out_d;
    logic [4:0]  reg_addr_q,  reg_addr_d;
    logic [15:0] wr_data_q,   wr_data_d;
    logic        wr_stb_q,    wr_stb_d;
    logic        rd_req_q,    rd_req_d;
    logic        frame_err_q, frame_err_d;

`ifdef MDIO_PREAMBLE_CHECK_EN
    localparam int PRE_W = $clog2(MIN_PRE + 1);
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             pre_ok_q,  pre_ok_d;  // preamble long enough before the ST '0'
`endif

    hdr_t       hdr_w;
    logic [4:0] n_inc;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        zero_seen_d = zero_seen_q;
        tail_d      = tail_q;
        hdr_sr_d    = hdr_sr_q;
        data_sr_d   = data_sr_q;
        rd_cap_d    = rd_req_q;
        oe_d        = oe_q;
        out_d       = out_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        wr_stb_d    = 1'b0;
        rd_req_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
        pre_cnt_d   = pre_cnt_q;
        pre_ok_d    = pre_ok_q;
`endif
        hdr_w = hdr_t'({hdr_sr_q, MDIO_IN});
        n_inc = n_q + 5'd1;

        if (rd_cap_q) begin
            data_sr_d = RD_DATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    if ({~zero_seen_q, MDIO_IN} == ST_CODE) begin
                        zero_seen_d = 1'b0;
                        n_d         = 5'd2;
`ifdef MDIO_PREAMBLE_CHECK_EN
                        pre_cnt_d = '0;
                        pre_ok_d  = 1'b0;
                        if (pre_ok_q) begin
                            state_d = ST_HDR;
                        end else begin
                            state_d     = ST_SKIP;
                            frame_err_d = 1'b1;
                        end
`else
                        state_d = ST_HDR;
`endif
                    end else begin
                        zero_seen_d = ~MDIO_IN;
`ifdef MDIO_PREAMBLE_CHECK_EN
                        if (MDIO_IN) begin
                            if (pre_cnt_q != PRE_W'(MIN_PRE)) begin
                                pre_cnt_d = pre_cnt_q + 1'b1;
                            end
                        end else begin
                            pre_ok_d  = (pre_cnt_q >= PRE_W'(MIN_PRE));
                            pre_cnt_d = '0;
                        end
`endif
                    end
                end
            end

            ST_HDR: begin
                if (rise) begin
                    hdr_sr_d = {hdr_sr_q[9:0], MDIO_IN};
                    n_d      = n_inc;
                    if (n_q == HDR_LAST) begin
                        if (hdr_w.op != OP_RD && hdr_w.op != OP_WR) begin
                            state_d     = ST_SKIP;
                            frame_err_d = 1'b1;
                        end else if (hdr_w.phyad != PHY_ADDR) begin
                            state_d = ST_SKIP;
                        end else begin
                            reg_addr_d = hdr_w.regad;
                            if (hdr_w.op == OP_RD) begin
                                state_d  = ST_RD_TA;
                                rd_req_d = 1'b1;
                            end else begin
                                state_d = ST_WR_TA;
                            end
                        end
                    end
                end
            end

            ST_WR_TA: begin
                if (rise) begin
                    data_sr_d = {data_sr_q[14:0], MDIO_IN};
                    n_d       = n_inc;
                    if (n_q == DATA_MSB - 5'd1) begin
                        if ({data_sr_q[0], MDIO_IN} == TA_WR) begin
                            state_d = ST_WR_DATA;
                        end else begin
                            state_d     = ST_SKIP;
                            frame_err_d = 1'b1;
                        end
                    end
                end
            end

            ST_WR_DATA: begin
                if (rise) begin
                    data_sr_d = {data_sr_q[14:0], MDIO_IN};
                    if (n_q == LAST_BIT) begin
                        wr_data_d = {data_sr_q[14:0], MDIO_IN};
                        wr_stb_d  = 1'b1;
                        state_d   = ST_IDLE;
                        n_d       = 5'd0;
                    end else begin
                        n_d = n_inc;
                    end
                end
            end

            ST_RD_TA: begin
                if (rise) begin
                    n_d = n_inc;
                end else if (fall && n_q == TA_BIT + 5'd1) begin
                    // Second turnaround bit: take the line, drive 0
                    oe_d    = 1'b1;
                    out_d   = 1'b0;
                    state_d = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (rise) begin
                    if (n_q == LAST_BIT) begin
                        tail_d = 1'b1;
                    end else begin
                        n_d = n_inc;
                    end
                end else if (fall) begin
                    if (tail_q) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                        tail_d  = 1'b0;
                        state_d = ST_IDLE;
                        n_d     = 5'd0;
                    end else begin
                        out_d     = data_sr_q[15];
                        data_sr_d = {data_sr_q[14:0], 1'b0};
                    end
                end
            end

            ST_SKIP: begin
                if (rise) begin
                    if (n_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        n_d     = 5'd0;
                    end else begin
                        n_d = n_inc;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                n_d     = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= 5'd0;
            zero_seen_q <= 1'b0;
            tail_q      <= 1'b0;
            hdr_sr_q    <= '0;
            data_sr_q   <= '0;
            rd_cap_q    <= 1'b0;
            oe_q        <= 1'b0;
            out_q       <= 1'b0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            wr_stb_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
            pre_cnt_q   <= '0;
            pre_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            zero_seen_q <= zero_seen_d;
            tail_q      <= tail_d;
            hdr_sr_q    <= hdr_sr_d;
            data_sr_q   <= data_sr_d;
            rd_cap_q    <= rd_cap_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            wr_stb_q    <= wr_stb_d;
            rd_req_q    <= rd_req_d;
            frame_err_q <= frame_err_d;
`ifdef MDIO_PREAMBLE_CHECK_EN
            pre_cnt_q   <= pre_cnt_d;
            pre_ok_q    <= pre_ok_d;
`endif
        end
    end

    assign MDIO_OUT  = out_q;
    assign MDIO_OE   = oe_q;
    assign REG_ADDR  = reg_addr_q;
    assign WR_DATA   = wr_data_q;
    assign WR_STB    = wr_stb_q;
    assign RD_REQ    = rd_req_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_mdio_receptor.sv
// -----------------------------------------------------------------------------
// tb_mdio_receptor
//   Drives Clause-22 frames with randomized MDC timing into mdio_receptor and
//   compares pulses, write data, register address and the returned serial
//   read waveform against a frame-level model with its own register image.
// -----------------------------------------------------------------------------
module tb_mdio_receptor;

    localparam logic [4:0] MY_ADDR  = 5'd3;
    localparam int         MIN_ONES = 32;
    localparam int         TRAIL    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MDC;
    logic        MDIO_IN;
    logic [15:0] RD_DATA;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [4:0]  REG_ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_REQ;
    logic        FRAME_ERR;

    mdio_receptor #(.PHY_ADDR(MY_ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .MDC       (MDC),
        .MDIO_IN   (MDIO_IN),
        .RD_DATA   (RD_DATA),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .REG_ADDR  (REG_ADDR),
        .WR_DATA   (WR_DATA),
        .WR_STB    (WR_STB),
        .RD_REQ    (RD_REQ),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Pulse monitor (sole writer of these counters)
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] wr_data_seen;
    logic [4:0]  wr_addr_seen;

    always @(negedge clk) begin
        if (WR_STB) begin
            wr_cnt       <= wr_cnt + 1;
            wr_data_seen <= WR_DATA;
            wr_addr_seen <= REG_ADDR;
        end
        if (RD_REQ)    rd_cnt  <= rd_cnt + 1;
        if (FRAME_ERR) err_cnt <= err_cnt + 1;
    end

    function automatic logic [15:0] init_val(input int i);
        return 16'(32'hC0DE ^ (i * 32'h0101));
    endfunction

    // PHY-side register bank, one clk read latency
    logic [15:0] bank [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
            RD_DATA <= '0;
        end else begin
            if (WR_STB) bank[REG_ADDR] <= WR_DATA;
            if (RD_REQ) RD_DATA <= bank[REG_ADDR];
        end
    end

    // Frame-level model state
    logic [15:0] mem_model [32];
    logic [4:0]  model_addr;
    int          ones_before;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_model[i] = init_val(i);
        model_addr  = '0;
        ones_before = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One MDC bit: fall + data, low phase, sample what the controller would
    // see at the rise, rise, high phase.
    task automatic mdc_bit(input logic b, output logic oe_s, output logic out_s);
        int lo;
        int hi;
        lo = $urandom_range(1, 3);
        hi = $urandom_range(1, 3);
        @(negedge clk);
        MDC     = 1'b0;
        MDIO_IN = b;
        repeat (lo) @(negedge clk);
        oe_s  = MDIO_OE;
        out_s = MDIO_OUT;
        MDC   = 1'b1;
        repeat (hi - 1) @(negedge clk);
    endtask

    task automatic send_ones(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) mdc_bit(1'b1, a, b);
    endtask

    task automatic run_frame(input logic [1:0] op, input logic [4:0] phyad, input logic [4:0] regad,
                             input logic [1:0] ta, input logic [15:0] data, input int pre_len,
                             input string tag);
        logic [31:0] frame, oe_obs, out_obs, oe_exp, out_exp;
        logic        oe_s, out_s, oe_after, pre_ok, exp_wr, exp_rd, exp_err;
        logic [15:0] rd_exp;
        int          wr0, rd0, er0;

        frame = {2'b01, op, phyad, regad, ta, data};
        wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
        send_ones(pre_len);
        for (int k = 0; k < 32; k++) begin
            mdc_bit(frame[31-k], oe_s, out_s);
            oe_obs[k]  = oe_s;
            out_obs[k] = out_s;
        end
        mdc_bit(1'b1, oe_after, out_s);
        mdc_bit(1'b1, oe_s, out_s);
        repeat (2) @(negedge clk);

`ifdef MDIO_PREAMBLE_CHECK_EN
        pre_ok = (ones_before + pre_len) >= MIN_ONES;
`else
        pre_ok = 1'b1;
`endif
        exp_wr = 1'b0; exp_rd = 1'b0; exp_err = 1'b0;
        oe_exp = '0; out_exp = '0; rd_exp = '0;
        if (!pre_ok || !(op == 2'b01 || op == 2'b10)) begin
            exp_err = 1'b1;
        end else if (phyad == MY_ADDR) begin
            model_addr = regad;
            if (op == 2'b10) begin
                exp_rd = 1'b1;
                rd_exp = mem_model[regad];
                for (int k = 15; k < 32; k++) oe_exp[k] = 1'b1;
                for (int k = 16; k < 32; k++) out_exp[k] = rd_exp[31-k];
            end else if (ta == 2'b10) begin
                exp_wr = 1'b1;
                mem_model[regad] = data;
            end else begin
                exp_err = 1'b1;
            end
        end
        ones_before = TRAIL;

        check({tag, ".wr_stb"},    32'(wr_cnt - wr0),  32'(exp_wr));
        check({tag, ".rd_req"},    32'(rd_cnt - rd0),  32'(exp_rd));
        check({tag, ".frame_err"}, 32'(err_cnt - er0), 32'(exp_err));
        check({tag, ".oe_bits"},   oe_obs,  oe_exp);
        check({tag, ".out_bits"},  out_obs, out_exp);
        check({tag, ".oe_after"},  32'(oe_after), 32'd0);
        check({tag, ".reg_addr"},  32'(REG_ADDR), 32'(model_addr));
        if (exp_wr) begin
            check({tag, ".wr_data"}, 32'(wr_data_seen), 32'(data));
            check({tag, ".wr_addr"}, 32'(wr_addr_seen), 32'(regad));
        end
    endtask

    int          pre_base;
    int          r;
    logic [1:0]  op_r, ta_r;
    logic [4:0]  phy_r, reg_r;
    logic [15:0] dat_r;
    logic [31:0] rframe;
    logic        oe_s, out_s;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MDIO_PREAMBLE_CHECK_EN
        pre_base = MIN_ONES;
`else
        pre_base = 0;
`endif
        rst = 1'b1; MDC = 1'b0; MDIO_IN = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.outs", {7'd0, MDIO_OUT, MDIO_OE, WR_STB, RD_REQ, FRAME_ERR, REG_ADDR, WR_DATA}, 32'd0);
        rst = 1'b0;

        // Directed frames
        run_frame(2'b01, MY_ADDR, 5'd5, 2'b10, 16'hA5A5, pre_base, "wr_a5a5");
        run_frame(2'b01, MY_ADDR, 5'd7, 2'b10, 16'h1234, pre_base, "wr_1234");
        run_frame(2'b10, MY_ADDR, 5'd7, 2'b11, 16'hFFFF, pre_base, "rd_1234");
        run_frame(2'b01, 5'd4,    5'd9, 2'b10, 16'hBEEF, pre_base, "miss");
        run_frame(2'b01, MY_ADDR, 5'd9, 2'b10, 16'h0F0F, pre_base, "after_miss");
        run_frame(2'b11, MY_ADDR, 5'd2, 2'b10, 16'h5555, pre_base, "bad_op");
        run_frame(2'b01, MY_ADDR, 5'd2, 2'b00, 16'h6666, pre_base, "bad_ta");
        run_frame(2'b10, MY_ADDR, 5'd2, 2'b00, 16'h0000, pre_base, "rd_unwritten");

        // Reset in the middle of a read data phase
        send_ones(pre_base);
        rframe = {2'b01, 2'b10, MY_ADDR, 5'd9, 2'b11, 16'hFFFF};
        for (int k = 0; k < 20; k++) mdc_bit(rframe[31-k], oe_s, out_s);
        check("rst.oe_before", 32'(oe_s), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        MDC = 1'b0;
        @(posedge clk);
        #1;
        check("rst.oe_same_edge", 32'(MDIO_OE), 32'd0);
        check("rst.outs", {7'd0, MDIO_OUT, MDIO_OE, WR_STB, RD_REQ, FRAME_ERR, REG_ADDR, WR_DATA}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_frame(2'b01, MY_ADDR, 5'd12, 2'b10, 16'hC3C3, pre_base, "post_rst_wr");
        run_frame(2'b10, MY_ADDR, 5'd12, 2'b01, 16'h0000, pre_base, "post_rst_rd");

`ifdef MDIO_PREAMBLE_CHECK_EN
        run_frame(2'b01, MY_ADDR, 5'd1, 2'b10, 16'h1111, MIN_ONES - 1 - ones_before, "pre_31");
        run_frame(2'b01, MY_ADDR, 5'd1, 2'b10, 16'h2222, MIN_ONES - ones_before, "pre_32");
`endif

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            r     = $urandom_range(0, 9);
            op_r  = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            phy_r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : MY_ADDR;
            reg_r = 5'($urandom);
            dat_r = 16'($urandom);
            ta_r  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b10;
            run_frame(op_r, phy_r, reg_r, ta_r, dat_r, pre_base + $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
